mmio_stream_fifo: RTL and testbench



---
 rtl/mmio_stream_fifo.sv | 139 +++++++++++++
 tb/tb_mmio_stream_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_stream_fifo.sv
// CPU load/store bus to valid/ready byte-stream bridge for the USB_CDC host side.
// Independent RX (host->CPU) and TX (CPU->host) FIFOs, status/ctrl/level registers, threshold IRQs.
module mmio_stream_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BUS_W     = 32,
    parameter int unsigned RX_DEPTH  = 16,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_THRESH = 1,
    parameter int unsigned TX_THRESH = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sel_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [1:0]        addr_i,
    input  logic [BUS_W-1:0]  data_i,
    output logic [BUS_W-1:0]  data_o,
    output logic              rx_irq_o,
    output logic              tx_irq_o,
    output logic [DATA_W-1:0] in_data_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    input  logic [DATA_W-1:0] out_data_i,
    input  logic              out_valid_i,
    output logic              out_ready_o
);

    localparam int unsigned RX_AW  = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW  = RX_AW + 1;
    localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW  = TX_AW + 1;
    localparam int unsigned HALF_W = BUS_W / 2;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];

    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [RX_CW-1:0] rx_count, rx_count_next;
    logic [TX_CW-1:0] tx_count, tx_count_next;
    logic [1:0]       ctrl, ctrl_next;
    logic             rx_underflow, tx_overflow;

    logic bus_rd, bus_wr;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rx_unf_set, tx_ovf_set, status_wr;
    logic [BUS_W-1:0] rd_data;
    logic data_unused;

    assign data_unused = ^data_i;

    assign bus_rd   = sel_i && read_i;
    assign bus_wr   = sel_i && write_i;
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));

    // Stream handshakes are forced idle while reset is held, even before counts clear.
    assign out_ready_o = !rst_i && !rx_full;
    assign in_valid_o  = !rst_i && !tx_empty;
    assign in_data_o   = tx_mem[tx_rd_ptr];

    assign rx_push    = out_valid_i && out_ready_o;
    assign rx_pop     = bus_rd && (addr_i == REG_DATA) && !rx_empty;
    assign tx_pop     = in_valid_o && in_ready_i;
    assign tx_push    = bus_wr && (addr_i == REG_DATA) && !tx_full;
    assign rx_unf_set = bus_rd && (addr_i == REG_DATA) && rx_empty;
    assign tx_ovf_set = bus_wr && (addr_i == REG_DATA) && tx_full;
    assign status_wr  = bus_wr && (addr_i == REG_STATUS);

    always_comb begin
        rx_count_next = rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
        tx_count_next = tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
        ctrl_next     = ctrl;
        if (bus_wr && (addr_i == REG_CTRL)) begin
            ctrl_next = data_i[1:0];
        end
    end

    // Combinational read mux; reflects pre-edge state.
    always_comb begin
        rd_data = '0;
        if (bus_rd && !rst_i) begin
            case (addr_i)
                REG_DATA:   if (!rx_empty) rd_data = BUS_W'(rx_mem[rx_rd_ptr]);
                REG_STATUS: rd_data[5:0] = {tx_irq_o, rx_irq_o, tx_overflow, rx_underflow,
                                            !tx_full, !rx_empty};
                REG_CTRL:   rd_data[1:0] = ctrl;
                REG_LEVEL:  rd_data = BUS_W'({HALF_W'(tx_count), HALF_W'(rx_count)});
                default:    rd_data = '0;
            endcase
        end
    end

    assign data_o = rd_data;

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= out_data_i;
        if (tx_push) tx_mem[tx_wr_ptr] <= data_i[DATA_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            rx_count     <= '0;
            tx_count     <= '0;
            ctrl         <= '0;
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
            rx_irq_o     <= 1'b0;
            tx_irq_o     <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            rx_count <= rx_count_next;
            tx_count <= tx_count_next;
            ctrl     <= ctrl_next;
            // A new set event wins over a same-cycle W1C clear.
            rx_underflow <= rx_unf_set | (rx_underflow & ~(status_wr & data_i[2]));
            tx_overflow  <= tx_ovf_set | (tx_overflow  & ~(status_wr & data_i[3]));
            rx_irq_o <= ctrl_next[0] && (rx_count_next >= RX_CW'(RX_THRESH));
            tx_irq_o <= ctrl_next[1] && (tx_count_next <= TX_CW'(TX_THRESH));
        end
    end

endmodule

// File: tb/tb_mmio_stream_fifo.sv
// Directed bench for mmio_stream_fifo: queue-based reference model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_mmio_stream_fifo;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BUS_W     = 32;
    localparam int unsigned RX_DEPTH  = 16;
    localparam int unsigned TX_DEPTH  = 16;
    localparam int unsigned RX_THRESH = 4;
    localparam int unsigned TX_THRESH = 0;

    logic              clk_i;
    logic              rst_i;
    logic              sel_i, read_i, write_i;
    logic [1:0]        addr_i;
    logic [BUS_W-1:0]  data_i, data_o;
    logic              rx_irq_o, tx_irq_o;
    logic [DATA_W-1:0] in_data_o;
    logic              in_valid_o, in_ready_i;
    logic [DATA_W-1:0] out_data_i;
    logic              out_valid_i, out_ready_o;

    int vectors     = 0;
    int miscompares = 0;

    mmio_stream_fifo #(
        .DATA_W(DATA_W), .BUS_W(BUS_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH),
        .RX_THRESH(RX_THRESH), .TX_THRESH(TX_THRESH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .read_i(read_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .rx_irq_o(rx_irq_o), .tx_irq_o(tx_irq_o),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the state that will hold after the next clock edge.
    logic [7:0] m_rx_q[$];
    logic [7:0] m_tx_q[$];
    logic       m_unf = 1'b0, m_ovf = 1'b0, m_rx_irq = 1'b0, m_tx_irq = 1'b0;
    logic [1:0] m_ctrl = 2'b00;
    logic [7:0] m_drop;
    logic [31:0] m_exp;
    int rxn, txn;
    logic m_rd, m_wr, m_unf_set, m_ovf_set;

    always @(negedge clk_i) begin
        rxn = m_rx_q.size();
        txn = m_tx_q.size();
        m_exp = 32'h0;
        if (!rst_i && sel_i && read_i) begin
            case (addr_i)
                2'd0: m_exp = (rxn > 0) ? {24'h0, m_rx_q[0]} : 32'h0;
                2'd1: m_exp = {26'h0, m_tx_irq, m_rx_irq, m_ovf, m_unf,
                               1'(txn != TX_DEPTH), 1'(rxn != 0)};
                2'd2: m_exp = {30'h0, m_ctrl};
                default: m_exp = {16'(txn), 16'(rxn)};
            endcase
        end
        chk("data_o", data_o, m_exp);
        chk("out_ready_o", 32'(out_ready_o), rst_i ? 32'h0 : 32'(rxn != RX_DEPTH));
        chk("in_valid_o", 32'(in_valid_o), rst_i ? 32'h0 : 32'(txn != 0));
        chk("rx_irq_o", 32'(rx_irq_o), 32'(m_rx_irq));
        chk("tx_irq_o", 32'(tx_irq_o), 32'(m_tx_irq));
        if (!rst_i && txn > 0) chk("in_data_o", 32'(in_data_o), 32'(m_tx_q[0]));

        if (rst_i) begin
            m_rx_q.delete();
            m_tx_q.delete();
            m_unf = 1'b0; m_ovf = 1'b0; m_ctrl = 2'b00; m_rx_irq = 1'b0; m_tx_irq = 1'b0;
        end else begin
            m_rd = sel_i && read_i;
            m_wr = sel_i && write_i;
            m_unf_set = m_rd && addr_i == 2'd0 && rxn == 0;
            m_ovf_set = m_wr && addr_i == 2'd0 && txn == TX_DEPTH;
            if (m_rd && addr_i == 2'd0 && rxn > 0) m_drop = m_rx_q.pop_front();
            if (out_valid_i && rxn < RX_DEPTH) m_rx_q.push_back(out_data_i);
            if (in_ready_i && txn > 0) m_drop = m_tx_q.pop_front();
            if (m_wr && addr_i == 2'd0 && txn < TX_DEPTH) m_tx_q.push_back(data_i[7:0]);
            if (m_wr && addr_i == 2'd1) begin
                if (data_i[2]) m_unf = 1'b0;
                if (data_i[3]) m_ovf = 1'b0;
            end
            if (m_unf_set) m_unf = 1'b1;
            if (m_ovf_set) m_ovf = 1'b1;
            if (m_wr && addr_i == 2'd2) m_ctrl = data_i[1:0];
            m_rx_irq = m_ctrl[0] && (m_rx_q.size() >= RX_THRESH);
            m_tx_irq = m_ctrl[1] && (m_tx_q.size() <= TX_THRESH);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_idle();
        sel_i = 1'b0; read_i = 1'b0; write_i = 1'b0; addr_i = 2'd0; data_i = '0;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
        sel_i = 1'b1; read_i = 1'b1; write_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        d = data_o;
        tick();
        bus_idle();
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] v);
        sel_i = 1'b1; read_i = 1'b0; write_i = 1'b1; addr_i = a; data_i = v;
        tick();
        bus_idle();
    endtask

    logic [31:0] d;

    initial begin
        rst_i = 1'b1;
        bus_idle();
        in_ready_i = 1'b0;
        out_valid_i = 1'b1;
        out_data_i = 8'h77;

        // Reset held with host data offered
        tick(); tick();
        @(negedge clk_i);
        chk("lit_rst_out_ready", 32'(out_ready_o), 32'h0);
        chk("lit_rst_in_valid", 32'(in_valid_o), 32'h0);
        tick();
        rst_i = 1'b0;
        out_valid_i = 1'b0;
        @(negedge clk_i);
        chk("lit_ready_after_rst", 32'(out_ready_o), 32'h1);
        tick();
        cpu_rd(2'd3, d);
        chk("lit_level_reset", d, 32'h0);

        // Host fills RX
        for (int i = 1; i <= 16; i++) begin
            out_valid_i = 1'b1; out_data_i = 8'(i);
            tick();
        end
        out_valid_i = 1'b0;
        @(negedge clk_i);
        chk("lit_rx_full_ready", 32'(out_ready_o), 32'h0);
        tick();
        cpu_rd(2'd3, d);
        chk("lit_level_16", d, 32'h0000_0010);
        for (int i = 1; i <= 16; i++) begin
            cpu_rd(2'd0, d);
            chk("lit_rx_data", d, 32'(i));
        end
        cpu_rd(2'd0, d);
        chk("lit_rx_underflow_read", d, 32'h0);
        cpu_rd(2'd1, d);
        chk("lit_status_unf", d, 32'h6);
        cpu_wr(2'd1, 32'h4);
        cpu_rd(2'd1, d);
        chk("lit_status_cleared", d, 32'h2);

        // CPU to host
        cpu_wr(2'd0, 32'hA5);
        cpu_wr(2'd0, 32'h5A);
        @(negedge clk_i);
        chk("lit_tx_valid", 32'(in_valid_o), 32'h1);
        chk("lit_tx_head", 32'(in_data_o), 32'hA5);
        tick();
        in_ready_i = 1'b1;
        @(negedge clk_i);
        chk("lit_tx_first", 32'(in_data_o), 32'hA5);
        tick();
        @(negedge clk_i);
        chk("lit_tx_second", 32'(in_data_o), 32'h5A);
        tick();
        @(negedge clk_i);
        chk("lit_tx_drained", 32'(in_valid_o), 32'h0);
        tick();
        in_ready_i = 1'b0;

        // Overflow with a same-cycle host pop
        for (int i = 1; i <= 16; i++) cpu_wr(2'd0, 32'(8'h10 + 8'(i)));
        in_ready_i = 1'b1;
        cpu_wr(2'd0, 32'hFF);
        in_ready_i = 1'b0;
        cpu_rd(2'd3, d);
        chk("lit_level_tx15", d, 32'h000F_0000);
        cpu_rd(2'd1, d);
        chk("lit_status_ovf", d, 32'hA);
        @(negedge clk_i);
        chk("lit_tx_head_after_ovf", 32'(in_data_o), 32'h12);
        tick();
        in_ready_i = 1'b1;
        repeat (15) tick();
        in_ready_i = 1'b0;
        @(negedge clk_i);
        chk("lit_tx_empty", 32'(in_valid_o), 32'h0);
        tick();
        cpu_wr(2'd1, 32'h8);

        // RX threshold interrupt
        cpu_wr(2'd2, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            out_valid_i = 1'b1; out_data_i = 8'(8'h30 + 8'(i));
            @(negedge clk_i);
            chk("lit_rx_irq_low", 32'(rx_irq_o), 32'h0);
            tick();
        end
        out_valid_i = 1'b0;
        @(negedge clk_i);
        chk("lit_rx_irq_high", 32'(rx_irq_o), 32'h1);
        tick();
        cpu_rd(2'd0, d);
        chk("lit_rx_irq_data", d, 32'h31);
        @(negedge clk_i);
        chk("lit_rx_irq_fell", 32'(rx_irq_o), 32'h0);
        tick();
        for (int i = 2; i <= 4; i++) begin
            cpu_rd(2'd0, d);
            chk("lit_rx_irq_drain", d, 32'(8'h30 + 8'(i)));
        end

        // TX threshold interrupt
        cpu_wr(2'd2, 32'h3);
        @(negedge clk_i);
        chk("lit_tx_irq_high", 32'(tx_irq_o), 32'h1);
        tick();
        cpu_wr(2'd0, 32'h66);
        @(negedge clk_i);
        chk("lit_tx_irq_low", 32'(tx_irq_o), 32'h0);
        tick();
        in_ready_i = 1'b1;
        tick(); tick();
        in_ready_i = 1'b0;
        @(negedge clk_i);
        chk("lit_tx_irq_back", 32'(tx_irq_o), 32'h1);
        tick();
        cpu_wr(2'd2, 32'h0);

        // Wrap-around and simultaneous push/pop at count 1
        for (int i = 0; i < 14; i++) begin
            out_valid_i = 1'b1; out_data_i = 8'(8'h40 + 8'(i));
            tick();
        end
        out_valid_i = 1'b0;
        for (int i = 0; i < 13; i++) begin
            cpu_rd(2'd0, d);
            chk("lit_wrap_data", d, 32'(8'h40 + 8'(i)));
        end
        out_valid_i = 1'b1; out_data_i = 8'h4E;
        cpu_rd(2'd0, d);
        out_valid_i = 1'b0;
        chk("lit_sim_old_head", d, 32'h4D);
        cpu_rd(2'd3, d);
        chk("lit_sim_level", d, 32'h1);
        cpu_rd(2'd0, d);
        chk("lit_sim_new_head", d, 32'h4E);

        // Reset mid-transfer discards contents
        out_valid_i = 1'b1; out_data_i = 8'h99;
        tick(); tick();
        out_valid_i = 1'b0;
        cpu_wr(2'd0, 32'h77);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        cpu_rd(2'd3, d);
        chk("lit_level_after_midrst", d, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
